// File: rtl/lsu_pkg.sv
// Shared constants and state type for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int BE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a returned memory word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   output logic [31:0] load_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = mem_rdata[7:0];
      case (offset)
         2'd1:    lane_b = mem_rdata[15:8];
         2'd2:    lane_b = mem_rdata[23:16];
         2'd3:    lane_b = mem_rdata[31:24];
         default: lane_b = mem_rdata[7:0];
      endcase
      lane_h = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      case (funct3)
         F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_data = {24'd0, lane_b};
         F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_data = {16'd0, lane_h};
         default: load_data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: decodes one load/store, runs req/gnt/rvalid toward
// memory, extends load results and reports misalignment/timeout faults.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic            lsu_is_store,
   input  logic [2:0]      lsu_funct3,
   input  logic [31:0]     lsu_addr,
   input  logic [31:0]     lsu_wdata,
   output logic            lsu_done,
   output logic [31:0]     lsu_rdata,
   output logic            lsu_misaligned,
   output logic            lsu_fault,
   output logic            mem_req,
   output logic            mem_we,
   output logic [31:0]     mem_addr,
   output logic [BE_W-1:0] mem_be,
   output logic [31:0]     mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [31:0]     mem_rdata
);

   // Handshakes: execute side transfers on lsu_valid && lsu_ready at a rising
   // edge and lsu_valid is held until then; memory side holds mem_req and its
   // payload until mem_gnt is sampled high, then waits for one mem_rvalid.

   lsu_state_t state, state_nxt;

   logic                 is_store_q;
   logic [2:0]           f3_q;
   logic [1:0]           off_q;
   logic [CNT_WIDTH-1:0] cnt;

   logic                 accept;
   logic                 unsup;
   logic                 misal;
   logic                 bypass;
   logic                 timeout;
   logic [BE_W-1:0]      be_d;
   logic [31:0]          wdata_d;
   logic [31:0]          load_data;

   assign accept  = lsu_valid && lsu_ready;
   assign bypass  = unsup || misal;
   assign timeout = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

   always_comb begin
      unsup   = 1'b0;
      misal   = 1'b0;
      be_d    = '0;
      wdata_d = '0;
      case (lsu_funct3)
         F3_B, F3_BU: begin
            be_d    = 4'b0001 << lsu_addr[1:0];
            wdata_d = {4{lsu_wdata[7:0]}};
            unsup   = lsu_is_store && lsu_funct3[2];
         end
         F3_H, F3_HU: begin
            be_d    = 4'b0011 << lsu_addr[1:0];
            wdata_d = {2{lsu_wdata[15:0]}};
            unsup   = lsu_is_store && lsu_funct3[2];
            misal   = lsu_addr[0] && !unsup;
         end
         F3_W: begin
            be_d    = 4'b1111;
            wdata_d = lsu_wdata;
            misal   = |lsu_addr[1:0];
         end
         default: unsup = 1'b1;
      endcase
   end

   lsu_load_align u_align (
      .mem_rdata (mem_rdata),
      .funct3    (f3_q),
      .offset    (off_q),
      .load_data (load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Timeout wins over a same-cycle gnt/rvalid so the budget is a hard limit.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = bypass ? S_DONE : S_REQ;
         S_REQ: begin
            if (timeout)      state_nxt = S_DONE;
            else if (mem_gnt) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (timeout || mem_rvalid) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      lsu_ready = (state == S_IDLE);
      mem_req   = (state == S_REQ);
      lsu_done  = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_store_q     <= 1'b0;
         f3_q           <= '0;
         off_q          <= '0;
         cnt            <= '0;
         lsu_rdata      <= '0;
         lsu_misaligned <= 1'b0;
         lsu_fault      <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_be         <= '0;
         mem_wdata      <= '0;
      end else if (accept) begin
         is_store_q     <= lsu_is_store;
         f3_q           <= lsu_funct3;
         off_q          <= lsu_addr[1:0];
         cnt            <= '0;
         lsu_rdata      <= '0;
         lsu_misaligned <= misal;
         lsu_fault      <= unsup;
         if (!bypass) begin
            mem_we    <= lsu_is_store;
            mem_addr  <= {lsu_addr[31:2], 2'b00};
            mem_be    <= be_d;
            mem_wdata <= wdata_d;
         end
      end else if (state == S_REQ || state == S_WAIT) begin
         cnt <= cnt + CNT_WIDTH'(1);
         if (timeout) begin
            lsu_fault <= 1'b1;
            lsu_rdata <= '0;
         end else if (state == S_WAIT && mem_rvalid && !is_store_q) begin
            lsu_rdata <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit with a size/sign model
// of RISC-V loads and stores and a cycle-exact memory responder.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic        lsu_is_store = 1'b0;
   logic [2:0]  lsu_funct3 = 3'd0;
   logic [31:0] lsu_addr = 32'd0;
   logic [31:0] lsu_wdata = 32'd0;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_misaligned;
   logic        lsu_fault;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   int errors = 0;
   int checks = 0;

   load_store_unit #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_is_store(lsu_is_store),
      .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_misaligned(lsu_misaligned),
      .lsu_fault(lsu_fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // 0 = memory access, 1 = misaligned, 2 = unsupported
   function automatic int ref_kind(input logic st, input logic [2:0] f3, input logic [31:0] a);
      int sz;
      if (f3 == 3 || f3 >= 6 || (st && f3 >= 4)) return 2;
      sz = f3 % 4;
      if (sz == 1 && (a % 2) != 0) return 1;
      if (sz == 2 && (a % 4) != 0) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int sz;
      sz = f3 % 4;
      if (sz == 0) return 32'd1 << (a % 4);
      if (sz == 1) return 32'd3 << (a % 4);
      return 32'd15;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
      int sz;
      sz = f3 % 4;
      if (sz == 0) return (d % 256) * 32'h01010101;
      if (sz == 1) return (d % 65536) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * (a % 4))) % 256;
      h = (w >> (16 * ((a % 4) / 2))) % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   // Issues one transaction, answers it after the given gnt/rvalid delays and
   // checks every handshake cycle plus the final result.
   task automatic do_access(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                            output logic [31:0] got);
      int kind;
      logic [31:0] exp_rd;
      kind = ref_kind(st, f3, a);
      exp_rd = (kind == 0 && !st) ? ref_load(f3, a, rd) : 32'd0;
      check({tag, " ready"}, lsu_ready, 1);
      lsu_valid = 1'b1; lsu_is_store = st; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
      step();
      lsu_valid = 1'b0;
      lsu_addr = $urandom; lsu_wdata = $urandom;
      if (kind != 0) begin
         check({tag, " bypass_done"}, lsu_done, 1);
         check({tag, " bypass_req"}, mem_req, 0);
         check({tag, " misaligned"}, lsu_misaligned, (kind == 1) ? 1 : 0);
         check({tag, " fault"}, lsu_fault, (kind == 2) ? 1 : 0);
         check({tag, " rdata"}, lsu_rdata, 0);
      end else begin
         for (int k = 0; k <= gnt_dly; k++) begin
            check({tag, " req"}, mem_req, 1);
            check({tag, " we"}, mem_we, st);
            check({tag, " addr"}, mem_addr, a & 32'hFFFFFFFC);
            check({tag, " be"}, mem_be, ref_be(f3, a));
            if (st) check({tag, " wdata"}, mem_wdata, ref_wdata(f3, wd));
            check({tag, " early_done"}, lsu_done, 0);
            mem_gnt = (k == gnt_dly);
            step();
            mem_gnt = 1'b0;
         end
         for (int k = 0; k <= rv_dly; k++) begin
            check({tag, " req_dropped"}, mem_req, 0);
            check({tag, " wait_done"}, lsu_done, 0);
            mem_rvalid = (k == rv_dly);
            mem_rdata = (k == rv_dly) ? rd : $urandom;
            step();
            mem_rvalid = 1'b0;
         end
         check({tag, " done"}, lsu_done, 1);
         check({tag, " rdata"}, lsu_rdata, exp_rd);
         check({tag, " flags"}, {lsu_misaligned, lsu_fault}, 0);
      end
      got = lsu_rdata;
      step();
      check({tag, " done_pulse"}, lsu_done, 0);
      check({tag, " idle"}, lsu_ready, 1);
      check({tag, " rdata_hold"}, lsu_rdata, exp_rd);
   endtask

   logic [31:0] got;
   logic [31:0] ld_word;
   int          n;

   initial begin
      #2;
      check("rst ready", lsu_ready, 1);
      check("rst done", lsu_done, 0);
      check("rst req", mem_req, 0);
      check("rst we", mem_we, 0);
      check("rst addr", mem_addr, 0);
      check("rst be", mem_be, 0);
      check("rst wdata", mem_wdata, 0);
      check("rst rdata", lsu_rdata, 0);
      check("rst flags", {lsu_misaligned, lsu_fault}, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      do_access("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, got);
      do_access("sb", 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0, got);
      check("sb be", mem_be, 32'h8);
      check("sb wdata", mem_wdata, 32'hA5A5A5A5);

      ld_word = 32'h1280FF34;
      do_access("lb", 0, 3'b000, 32'h102, 0, 0, 0, ld_word, got);
      check("lb const", got, 32'hFFFFFF80);
      do_access("lbu", 0, 3'b100, 32'h102, 0, 1, 0, ld_word, got);
      check("lbu const", got, 32'h00000080);
      do_access("lh", 0, 3'b001, 32'h102, 0, 0, 1, ld_word, got);
      check("lh const", got, 32'h00001280);
      do_access("lhu", 0, 3'b101, 32'h100, 0, 0, 0, ld_word, got);
      check("lhu const", got, 32'h0000FF34);
      do_access("lh0", 0, 3'b001, 32'h100, 0, 0, 0, ld_word, got);
      check("lh0 const", got, 32'hFFFFFF34);
      do_access("lw", 0, 3'b010, 32'h100, 0, 0, 0, ld_word, got);
      check("lw const", got, 32'h1280FF34);

      do_access("lh_mis", 0, 3'b001, 32'h101, 0, 0, 0, 0, got);
      do_access("f3_011", 0, 3'b011, 32'h100, 0, 0, 0, 0, got);
      do_access("sbu", 1, 3'b100, 32'h100, 0, 0, 0, 0, got);

      // Timeout: grant withheld three cycles, then no response at all.
      lsu_valid = 1'b1; lsu_is_store = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h200;
      step();
      lsu_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("to req", mem_req, 1);
         check("to addr", mem_addr, 32'h200);
         check("to be", mem_be, 32'hF);
         mem_gnt = (k == 3);
         step();
         mem_gnt = 1'b0;
      end
      n = 4;
      while (!lsu_done && n < 20) begin
         step();
         n++;
      end
      check("to cycles", n, 8);
      check("to fault", lsu_fault, 1);
      check("to rdata", lsu_rdata, 0);
      check("to req_low", mem_req, 0);
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      step();
      check("late done_low", lsu_done, 0);
      step();
      check("late idle_done", lsu_done, 0);
      check("late ready", lsu_ready, 1);
      check("late fault_hold", lsu_fault, 1);
      mem_rvalid = 1'b0;
      do_access("after_to", 0, 3'b010, 32'h204, 0, 1, 1, 32'hCAFEF00D, got);

      // Asynchronous reset while in REQ, then while in WAIT.
      lsu_valid = 1'b1; lsu_is_store = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h300;
      step();
      lsu_valid = 1'b0;
      check("rreq req", mem_req, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rreq req_fall", mem_req, 0);
      check("rreq ready", lsu_ready, 1);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("rreq no_done", lsu_done, 0);
      end
      lsu_valid = 1'b1; lsu_addr = 32'h304;
      step();
      lsu_valid = 1'b0;
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      check("rwait req", mem_req, 0);
      check("rwait busy", lsu_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      check("rwait ready", lsu_ready, 1);
      check("rwait req", mem_req, 0);
      check("rwait rdata", lsu_rdata, 0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mem_rvalid = (k == 0);
         step();
         check("rwait no_done", lsu_done, 0);
      end
      mem_rvalid = 1'b0;
      do_access("post_rst", 0, 3'b010, 32'h308, 0, 0, 0, 32'h0BADBEEF, got);

      for (int i = 0; i < 40; i++) begin
         do_access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom, got);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
